// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD time-of-day / countdown engine.
// Holds HH:MM:SS (or MM:SS when HOUR_EN=0) in packed BCD and advances it once
// every TICK_DIV enabled CLK1 cycles. Up-count rolls over at HOUR_MAX:59:59;
// down-count stops at zero and raises a sticky expired flag.
//
// Ports:
//   CLK1      clock, rising edge
//   RESET     asynchronous, active-high reset
//   run       1 = prescaler advances / steps taken, 0 = hold everything
//   dir       0 = count up, 1 = count down
//   clear     synchronous clear of time, prescaler and flags
//   load      one-cycle strobe to load load_bcd (validated)
//   load_bcd  {hr10,hr01,min10,min01,sec10,sec01}
//   time_bcd  current value, same packing
//   step      pulse on every step taken (including a held step at zero)
//   wrap      pulse when an up-count rolls over to zero
//   expired   sticky, set when a down-count reaches or sits at zero
//   load_err  pulse after a rejected load
module bcd_time_counter #(
  parameter int unsigned HOUR_EN  = 1,
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        CLK1,
  input  logic        RESET,
  input  logic        run,
  input  logic        dir,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_bcd,
  output logic [23:0] time_bcd,
  output logic        step,
  output logic        wrap,
  output logic        expired,
  output logic        load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [6:0] HMAX = 7'(HOUR_MAX);
  localparam bit HOURS_ON = (HOUR_EN != 0);

  logic [PW-1:0] pcnt;

  logic [3:0] s1, s10, m1, m10, h1, h10;
  logic [6:0] hr_val;

  assign {h10, h1, m10, m1, s10, s1} = time_bcd;
  assign hr_val = ({3'b000, h10} * 7'd10) + {3'b000, h1};

  // Up-count next value and rollover flag
  logic [3:0] u_s1, u_s10, u_m1, u_m10, u_h1, u_h10;
  logic       c_s1, c_s10, c_m1, c_m10;
  logic       up_wrap;

  always_comb begin
    u_s1    = s1;
    u_s10   = s10;
    u_m1    = m1;
    u_m10   = m10;
    u_h1    = h1;
    u_h10   = h10;
    up_wrap = 1'b0;

    c_s1  = (s1 == 4'd9);
    c_s10 = c_s1 && (s10 == 4'd5);
    c_m1  = c_s10 && (m1 == 4'd9);
    c_m10 = c_m1 && (m10 == 4'd5);

    u_s1 = c_s1 ? 4'd0 : s1 + 4'd1;
    if (c_s1)  u_s10 = (s10 == 4'd5) ? 4'd0 : s10 + 4'd1;
    if (c_s10) u_m1  = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
    if (c_m1)  u_m10 = (m10 == 4'd5) ? 4'd0 : m10 + 4'd1;
    if (c_m10) begin
      if (!HOURS_ON || (hr_val >= HMAX)) begin
        u_h1    = 4'd0;
        u_h10   = 4'd0;
        up_wrap = 1'b1;
      end else if (h1 == 4'd9) begin
        u_h1  = 4'd0;
        u_h10 = h10 + 4'd1;
      end else begin
        u_h1 = h1 + 4'd1;
      end
    end
  end

  // Down-count next value; zero holds rather than underflowing
  logic [3:0] d_s1, d_s10, d_m1, d_m10, d_h1, d_h10;
  logic       b_s1, b_s10, b_m1, b_m10;
  logic       is_zero;

  always_comb begin
    d_s1  = s1;
    d_s10 = s10;
    d_m1  = m1;
    d_m10 = m10;
    d_h1  = h1;
    d_h10 = h10;

    is_zero = (time_bcd == 24'h000000);
    b_s1  = (s1 == 4'd0);
    b_s10 = b_s1 && (s10 == 4'd0);
    b_m1  = b_s10 && (m1 == 4'd0);
    b_m10 = b_m1 && (m10 == 4'd0);

    if (!is_zero) begin
      d_s1 = b_s1 ? 4'd9 : s1 - 4'd1;
      if (b_s1)  d_s10 = (s10 == 4'd0) ? 4'd5 : s10 - 4'd1;
      if (b_s10) d_m1  = (m1 == 4'd0) ? 4'd9 : m1 - 4'd1;
      if (b_m1)  d_m10 = (m10 == 4'd0) ? 4'd5 : m10 - 4'd1;
      // Nonzero value with a borrow out of min10 implies nonzero hours
      if (b_m10) begin
        if (h1 == 4'd0) begin
          d_h1  = 4'd9;
          d_h10 = h10 - 4'd1;
        end else begin
          d_h1 = h1 - 4'd1;
        end
      end
    end
  end

  logic [23:0] next_time;
  always_comb begin
    next_time = dir ? {d_h10, d_h1, d_m10, d_m1, d_s10, d_s1}
                    : {u_h10, u_h1, u_m10, u_m1, u_s10, u_s1};
    if (!HOURS_ON) next_time[23:16] = 8'h00;
  end

  // Load validation
  logic [3:0] l_s1, l_s10, l_m1, l_m10, l_h1, l_h10;
  logic [6:0] l_hr;
  logic       load_ok;

  assign {l_h10, l_h1, l_m10, l_m1, l_s10, l_s1} = load_bcd;
  assign l_hr = ({3'b000, l_h10} * 7'd10) + {3'b000, l_h1};

  always_comb begin
    load_ok = (l_s1 <= 4'd9) && (l_s10 <= 4'd5) && (l_m1 <= 4'd9) && (l_m10 <= 4'd5) &&
              (l_h1 <= 4'd9) && (l_h10 <= 4'd9) && (l_hr <= HMAX);
    if (!HOURS_ON && ((l_h1 != 4'd0) || (l_h10 != 4'd0))) load_ok = 1'b0;
  end

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      time_bcd <= 24'h000000;
      pcnt     <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      step     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        time_bcd <= 24'h000000;
        pcnt     <= '0;
        expired  <= 1'b0;
      end else if (load) begin
        if (load_ok) begin
          time_bcd <= load_bcd;
          pcnt     <= '0;
          expired  <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run) begin
        if (pcnt == PMAX) begin
          pcnt     <= '0;
          step     <= 1'b1;
          time_bcd <= next_time;
          if (dir) begin
            // Landing on zero and holding at zero both (re)assert expired
            if (next_time == 24'h000000) expired <= 1'b1;
          end else begin
            wrap <= up_wrap;
          end
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

  logic        CLK1 = 1'b0;
  logic        RESET;
  logic        run, dir, clear, load;
  logic [23:0] load_bcd;

  logic [23:0] ta, tb, tc, td;
  logic        sa, sb, sc, sd;
  logic        wa, wb, wc, wd;
  logic        ea, eb, ec, ed;
  logic        la, lb, lc, ld;

  int total = 0;
  int bad = 0;

  always #5 CLK1 = ~CLK1;

  // a: TICK_DIV=4, b: TICK_DIV=1, c: MM:SS only, d: TICK_DIV=8
  bcd_time_counter #(.HOUR_EN(1), .HOUR_MAX(23), .TICK_DIV(4)) u_a (
    .CLK1(CLK1), .RESET(RESET), .run(run), .dir(dir), .clear(clear), .load(load),
    .load_bcd(load_bcd), .time_bcd(ta), .step(sa), .wrap(wa), .expired(ea), .load_err(la));
  bcd_time_counter #(.HOUR_EN(1), .HOUR_MAX(23), .TICK_DIV(1)) u_b (
    .CLK1(CLK1), .RESET(RESET), .run(run), .dir(dir), .clear(clear), .load(load),
    .load_bcd(load_bcd), .time_bcd(tb), .step(sb), .wrap(wb), .expired(eb), .load_err(lb));
  bcd_time_counter #(.HOUR_EN(0), .HOUR_MAX(23), .TICK_DIV(1)) u_c (
    .CLK1(CLK1), .RESET(RESET), .run(run), .dir(dir), .clear(clear), .load(load),
    .load_bcd(load_bcd), .time_bcd(tc), .step(sc), .wrap(wc), .expired(ec), .load_err(lc));
  bcd_time_counter #(.HOUR_EN(1), .HOUR_MAX(23), .TICK_DIV(8)) u_d (
    .CLK1(CLK1), .RESET(RESET), .run(run), .dir(dir), .clear(clear), .load(load),
    .load_bcd(load_bcd), .time_bcd(td), .step(sd), .wrap(wd), .expired(ed), .load_err(ld));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [23:0] v);
    load_bcd = v;
    load = 1'b1;
    @(negedge CLK1);
    load = 1'b0;
  endtask

  initial begin
    int nsteps;
    int spacing_err;
    RESET = 1'b1; run = 1'b0; dir = 1'b0; clear = 1'b0; load = 1'b0; load_bcd = '0;
    @(negedge CLK1);
    @(negedge CLK1);
    chk("reset_time", 32'(ta), 32'h000000);
    chk("reset_flags", {28'd0, sa, wa, ea, la}, 32'h0);

    // Up-count, TICK_DIV=4: 10 steps in 40 cycles
    RESET = 1'b0; run = 1'b1; dir = 1'b0;
    nsteps = 0; spacing_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK1);
      if (sa) nsteps++;
      if (sa !== ((i % 4) == 3)) spacing_err++;
    end
    chk("div4_time", 32'(ta), 32'h000010);
    chk("div4_steps", 32'(nsteps), 32'd10);
    chk("div4_spacing", 32'(spacing_err), 32'd0);

    // Rollover at 23:59:59
    run = 1'b0;
    do_load(24'h235958);
    chk("load_235958", 32'(tb), 32'h235958);
    run = 1'b1;
    @(negedge CLK1);
    chk("up_235959", 32'(tb), 32'h235959);
    chk("up_235959_wrap", 32'(wb), 32'd0);
    @(negedge CLK1);
    chk("roll_time", 32'(tb), 32'h000000);
    chk("roll_wrap", {30'd0, wb, sb}, 32'h3);
    run = 1'b0;
    @(negedge CLK1);
    chk("roll_wrap_pulse", 32'(wb), 32'd0);

    // Countdown from 00:01:00
    dir = 1'b1;
    do_load(24'h000100);
    run = 1'b1;
    for (int i = 1; i <= 61; i++) begin
      @(negedge CLK1);
      if (i == 1) chk("dn_first", 32'(tb), 32'h000059);
      if (i == 59) chk("dn_59", {7'd0, eb, tb}, {8'h00, 24'h000001});
      if (i == 60) chk("dn_zero", {7'd0, eb, tb}, {8'h01, 24'h000000});
      if (i == 61) chk("dn_hold", {6'd0, sb, eb, tb}, {8'h03, 24'h000000});
    end
    run = 1'b0;

    // Rejected loads, clear+load, accepted loads
    do_load(24'h000001);
    run = 1'b1;
    @(negedge CLK1);
    run = 1'b0;
    chk("dn_to_zero", {7'd0, eb, tb}, {8'h01, 24'h000000});
    do_load(24'h240000);
    chk("rej24_err", 32'(lb), 32'd1);
    chk("rej24_keep", {7'd0, eb, tb}, {8'h01, 24'h000000});
    @(negedge CLK1);
    chk("rej_err_pulse", 32'(lb), 32'd0);
    clear = 1'b1;
    do_load(24'h240000);
    clear = 1'b0;
    chk("clr_load", {6'd0, lb, eb, tb}, 32'h0);
    do_load(24'h123456);
    chk("load_123456", 32'(tb), 32'h123456);
    do_load(24'h240000);
    chk("rej24_retain", {7'd0, lb, tb}, {8'h01, 24'h123456});
    do_load(24'h006000);
    chk("rej60_retain", {7'd0, lb, tb}, {8'h01, 24'h123456});
    do_load(24'h120000);
    chk("load_120000", {6'd0, lb, eb, tb}, {8'h00, 24'h120000});

    // MM:SS variant
    dir = 1'b0;
    do_load(24'h005959);
    chk("mmss_load", 32'(tc), 32'h005959);
    run = 1'b1;
    @(negedge CLK1);
    run = 1'b0;
    chk("mmss_wrap", {7'd0, wc, tc}, {8'h01, 24'h000000});
    do_load(24'h010000);
    chk("mmss_rej", {7'd0, lc, tc}, {8'h01, 24'h000000});

    // Pause mid-interval, TICK_DIV=8
    clear = 1'b1;
    @(negedge CLK1);
    clear = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge CLK1);
    run = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK1);
      if (sd) nsteps++;
    end
    chk("pause_nostep", {8'd0, td} | 32'(nsteps), 32'd0);
    run = 1'b1;
    @(negedge CLK1);
    chk("resume_1", 32'(sd), 32'd0);
    @(negedge CLK1);
    chk("resume_2", 32'(sd), 32'd0);
    @(negedge CLK1);
    chk("resume_3", {7'd0, sd, td}, {8'h01, 24'h000001});

    // Asynchronous reset between edges
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_d", {7'd0, sd, td}, 32'h0);
    chk("async_rst_b", {4'd0, sb, wb, eb, lb, tb}, 32'h0);
    @(negedge CLK1);
    chk("rst_held_a", {4'd0, sa, wa, ea, la, ta}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
